// File: rtl/fetch_control_pkg.sv
// fetch_control_pkg: fetch-stage control encodings and front-end FSM states
package fetch_control_pkg;
  localparam logic [1:0] COND_FLOW  = 2'b00;
  localparam logic [1:0] COND_STALL = 2'b01;
  localparam logic [1:0] COND_ZERO  = 2'b10;

  localparam logic [2:0] PCSEL_EXT  = 3'd0;
  localparam logic [2:0] PCSEL_RS   = 3'd1;
  localparam logic [2:0] PCSEL_INTR = 3'd2;
  localparam logic [2:0] PCSEL_EPC  = 3'd3;
  localparam logic [2:0] PCSEL_J    = 3'd4;
  localparam logic [2:0] PCSEL_SEQ  = 3'd5;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_RUN,
    ST_MD_WAIT,
    ST_INT_FLUSH,
    ST_INT_REDIR,
    ST_HALT
  } state_t;
endpackage

// File: rtl/fetch_control_md_stall_counter.sv
// fetch_control_md_stall_counter: loadable down-counter timing a mult/div stall
module fetch_control_md_stall_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);
  logic [CNT_W-1:0] r_cnt;

  // load wins over decrement; decrement saturates at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  // done on the last wait cycle so the FSM leaves on the following edge
  assign o_done = r_cnt == CNT_W'(1);
endmodule

// File: rtl/fetch_control.sv
// fetch_control: fetch-stage cond / next-PC select and ID flush generation
module fetch_control
  import fetch_control_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = $clog2(MD_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_branch_taken,
  input  logic       id_jump,
  input  logic       id_jr,
  input  logic       id_eret,
  input  logic       load_use,
  input  logic       md_start,
  input  logic       intr_req,
  input  logic       cp0_ie,
  input  logic       halt_req,
  output logic [1:0] cond,
  output logic [2:0] mux_pc_sel,
  output logic       id_flush,
  output logic       intr_ack,
  output logic       busy
);
  state_t r_state;
  state_t w_next;
  logic   w_load;
  logic   w_done;

  fetch_control_md_stall_counter #(.CNT_W(CNT_W)) u_md_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_load_val(CNT_W'(MD_CYCLES - 1)),
    .i_dec     (r_state == ST_MD_WAIT),
    .o_done    (w_done)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_INIT;
    else r_state <= w_next;
  end

  // outputs and next state; in RUN the first matching request wins
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    cond       = COND_FLOW;
    mux_pc_sel = PCSEL_SEQ;
    id_flush   = 1'b0;
    intr_ack   = 1'b0;
    case (r_state)
      ST_INIT: begin
        cond     = COND_ZERO;
        id_flush = 1'b1;
        w_next   = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req) begin
          cond     = COND_STALL;
          id_flush = 1'b1;
          w_next   = ST_HALT;
        end else if (id_eret) begin
          mux_pc_sel = PCSEL_EPC;
          id_flush   = 1'b1;
        end else if (intr_req && cp0_ie) begin
          cond     = COND_STALL;
          id_flush = 1'b1;
          intr_ack = 1'b1;
          w_next   = ST_INT_FLUSH;
        end else if (md_start) begin
          cond   = COND_STALL;
          w_load = 1'b1;
          w_next = ST_MD_WAIT;
        end else if (load_use) begin
          cond = COND_STALL;
        end else if (id_jr) begin
          mux_pc_sel = PCSEL_RS;
          id_flush   = 1'b1;
        end else if (id_branch_taken) begin
          mux_pc_sel = PCSEL_EXT;
          id_flush   = 1'b1;
        end else if (id_jump) begin
          mux_pc_sel = PCSEL_J;
          id_flush   = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        cond   = COND_STALL;
        w_next = w_done ? ST_RUN : ST_MD_WAIT;
      end
      ST_INT_FLUSH: begin
        cond     = COND_STALL;
        id_flush = 1'b1;
        w_next   = ST_INT_REDIR;
      end
      ST_INT_REDIR: begin
        mux_pc_sel = PCSEL_INTR;
        id_flush   = 1'b1;
        w_next     = ST_RUN;
      end
      ST_HALT: cond = COND_STALL;
      default: begin
        cond     = COND_ZERO;
        id_flush = 1'b1;
        w_next   = ST_INIT;
      end
    endcase
  end

  assign busy = r_state != ST_RUN;
endmodule

// File: tb/tb_fetch_control.sv
// tb_fetch_control: directed checks of fetch_control with a 4-cycle mult/div
module tb_fetch_control;
  import fetch_control_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_branch_taken = 1'b0, id_jump = 1'b0, id_jr = 1'b0, id_eret = 1'b0;
  logic load_use = 1'b0, md_start = 1'b0, intr_req = 1'b0, cp0_ie = 1'b0, halt_req = 1'b0;
  logic [1:0] cond;
  logic [2:0] mux_pc_sel;
  logic id_flush, intr_ack, busy;
  int n_cmp = 0;
  int n_bad = 0;

  fetch_control #(.MD_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_branch_taken(id_branch_taken),
    .id_jump        (id_jump),
    .id_jr          (id_jr),
    .id_eret        (id_eret),
    .load_use       (load_use),
    .md_start       (md_start),
    .intr_req       (intr_req),
    .cp0_ie         (cp0_ie),
    .halt_req       (halt_req),
    .cond           (cond),
    .mux_pc_sel     (mux_pc_sel),
    .id_flush       (id_flush),
    .intr_ack       (intr_ack),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // packs {cond, sel, flush, ack, busy} into one comparable byte
  function automatic logic [7:0] pk(input logic [1:0] c, input logic [2:0] s,
                                    input logic f, input logic a, input logic b);
    return {c, s, f, a, b};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got cond/sel/flush/ack/busy=%b, want %b", tag, got, exp);
    end
  endtask

  task automatic idle();
    {id_branch_taken, id_jump, id_jr, id_eret, load_use, md_start, intr_req, cp0_ie, halt_req} = '0;
  endtask

  logic [7:0] obs;
  assign obs = {cond, mux_pc_sel, id_flush, intr_ack, busy};

  initial begin
    @(negedge clk); #1;
    check("rst", obs, pk(COND_ZERO, PCSEL_SEQ, 1, 0, 1));
    rst = 1'b0; #1;
    check("init", obs, pk(COND_ZERO, PCSEL_SEQ, 1, 0, 1));
    @(negedge clk); #1;
    check("run_idle", obs, pk(COND_FLOW, PCSEL_SEQ, 0, 0, 0));
    @(negedge clk); id_branch_taken = 1; load_use = 1; #1;
    check("lu_wins", obs, pk(COND_STALL, PCSEL_SEQ, 0, 0, 0));
    @(negedge clk); load_use = 0; #1;
    check("branch", obs, pk(COND_FLOW, PCSEL_EXT, 1, 0, 0));
    @(negedge clk); id_branch_taken = 0; id_jr = 1; id_jump = 1; #1;
    check("jr", obs, pk(COND_FLOW, PCSEL_RS, 1, 0, 0));
    @(negedge clk); id_jr = 0; #1;
    check("jump", obs, pk(COND_FLOW, PCSEL_J, 1, 0, 0));
    @(negedge clk); id_jump = 0; md_start = 1; id_branch_taken = 1; #1;
    check("md0", obs, pk(COND_STALL, PCSEL_SEQ, 0, 0, 0));
    @(negedge clk); idle(); intr_req = 1; cp0_ie = 1; load_use = 1; #1;
    check("md1", obs, pk(COND_STALL, PCSEL_SEQ, 0, 0, 1));
    @(negedge clk); #1;
    check("md2", obs, pk(COND_STALL, PCSEL_SEQ, 0, 0, 1));
    @(negedge clk); #1;
    check("md3", obs, pk(COND_STALL, PCSEL_SEQ, 0, 0, 1));
    @(negedge clk); #1;
    check("ack", obs, pk(COND_STALL, PCSEL_SEQ, 1, 1, 0));
    @(negedge clk); intr_req = 0; #1;
    check("int_flush", obs, pk(COND_STALL, PCSEL_SEQ, 1, 0, 1));
    @(negedge clk); #1;
    check("int_redir", obs, pk(COND_FLOW, PCSEL_INTR, 1, 0, 1));
    @(negedge clk); load_use = 0; #1;
    check("post_int", obs, pk(COND_FLOW, PCSEL_SEQ, 0, 0, 0));
    @(negedge clk); intr_req = 1; cp0_ie = 0; #1;
    check("no_ie", obs, pk(COND_FLOW, PCSEL_SEQ, 0, 0, 0));
    @(negedge clk); cp0_ie = 1; id_eret = 1; #1;
    check("eret", obs, pk(COND_FLOW, PCSEL_EPC, 1, 0, 0));
    @(negedge clk); id_eret = 0; #1;
    check("ack2", obs, pk(COND_STALL, PCSEL_SEQ, 1, 1, 0));
    @(negedge clk); intr_req = 0; #1;
    check("int_flush2", obs, pk(COND_STALL, PCSEL_SEQ, 1, 0, 1));
    @(negedge clk); #1;
    check("int_redir2", obs, pk(COND_FLOW, PCSEL_INTR, 1, 0, 1));
    @(negedge clk); halt_req = 1; intr_req = 1; id_eret = 1; md_start = 1; #1;
    check("halt0", obs, pk(COND_STALL, PCSEL_SEQ, 1, 0, 0));
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      {id_branch_taken, id_jump, id_jr, id_eret, load_use, md_start, intr_req, cp0_ie, halt_req} = 9'($urandom);
      #1;
      check("halt", obs, pk(COND_STALL, PCSEL_SEQ, 0, 0, 1));
    end
    @(negedge clk); idle(); rst = 1; #1;
    check("rst2", obs, pk(COND_ZERO, PCSEL_SEQ, 1, 0, 1));
    rst = 0;
    @(negedge clk); #1;
    check("run2", obs, pk(COND_FLOW, PCSEL_SEQ, 0, 0, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_control.md
Name: fetch_control

Overview:
- Front-end control for the 5-stage MIPS pipeline: generates the fetch-stage `cond` (flow/stall/zero) and `mux_pc_sel` every cycle, plus an ID-stage flush.
- Sources: decode-stage redirect requests, load-use hazards, multi-cycle multiply/divide, CP0 interrupt entry, eret and halt.
- Drives the fetch stage's control inputs; sits between ID-stage decode/hazard logic and the fetch stage.

Parameters:
- MD_CYCLES, 32, total stall cycles for a mult/div operation (≥2).
- CNT_W, $clog2(MD_CYCLES+1), width of the mult/div down-counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- id_branch_taken  in  1  conditional branch in ID resolved taken.
- id_jump  in  1  j/jal in ID.
- id_jr  in  1  jr/jalr in ID.
- id_eret  in  1  eret in ID.
- load_use  in  1  load-use hazard detected in ID.
- md_start  in  1  mult/div issued this cycle (single-cycle pulse).
- intr_req  in  1  CP0 pending interrupt, level.
- cp0_ie  in  1  CP0 global interrupt enable.
- halt_req  in  1  syscall/halt detected in ID.
- cond  out  2  fetch-stage control (encodings below).
- mux_pc_sel  out  3  next-PC source select.
- id_flush  out  1  zero the ID-stage instruction register next edge.
- intr_ack  out  1  one-cycle pulse; CP0 captures EPC and clears EXL-pending.
- busy  out  1  high in any state other than RUN.

Behaviour:
- Encodings:
  - COND_FLOW=2'b00, COND_STALL=2'b01, COND_ZERO=2'b10.
  - PCSEL_EXT=3'd0, PCSEL_RS=3'd1, PCSEL_INTR=3'd2, PCSEL_EPC=3'd3, PCSEL_J=3'd4, PCSEL_SEQ=3'd5.
- Outputs are combinational from registered state and current inputs. No output registering; the fetch stage consumes them in the same cycle.
- States: INIT, RUN, MD_WAIT, INT_FLUSH, INT_REDIR, HALT.
- Async reset:
  - state=INIT, counter=0.
  - Outputs while INIT: cond=ZERO, mux_pc_sel=SEQ, id_flush=1, intr_ack=0, busy=1.
- INIT → RUN unconditionally after one clock.
- RUN: evaluate in strict priority order; the first match decides outputs and next state.
  1. halt_req: cond=STALL, id_flush=1; → HALT.
  2. id_eret: cond=FLOW, sel=EPC, id_flush=1. Any simultaneous interrupt is deferred to the next RUN cycle.
  3. intr_req & cp0_ie: cond=STALL, id_flush=1, intr_ack=1; → INT_FLUSH.
  4. md_start: cond=STALL; counter←MD_CYCLES-1; → MD_WAIT.
  5. load_use: cond=STALL, sel=SEQ, id_flush=0.
  6. id_jr: cond=FLOW, sel=RS, id_flush=1.
  7. id_branch_taken: cond=FLOW, sel=EXT, id_flush=1.
  8. id_jump: cond=FLOW, sel=J, id_flush=1.
  9. Otherwise: cond=FLOW, sel=SEQ.
- MD_WAIT:
  - cond=STALL; counter decrements each cycle.
  - When counter==1, → RUN (exactly MD_CYCLES stall cycles including the md_start cycle).
  - Interrupts, redirects and load_use are ignored until return to RUN.
- INT_FLUSH: cond=STALL, id_flush=1; → INT_REDIR.
- INT_REDIR: cond=FLOW, sel=INTR, id_flush=1; → RUN.
- HALT: cond=STALL permanently; only reset exits.
- intr_ack is asserted for exactly one cycle per interrupt entry. intr_req deasserting after acceptance does not abort the sequence.
- mux_pc_sel=SEQ whenever cond≠FLOW, except where stated above.
- Reset asserted mid-sequence (any state) → INIT immediately; counter cleared; no intr_ack.

Decomposition:
- Shared package/header: COND_* and PCSEL_* constants (shared with the fetch stage and the PC mux), plus the state encodings.
- One sub-module is natural: md_stall_counter, a loadable down-counter with a done flag, parameterised by CNT_W.
- FSM and priority logic stay in fetch_control.

Test Plan:
- Reset release → first cycle cond=2'b10, id_flush=1. Next cycle cond=00, sel=5.
- id_branch_taken=1 together with load_use=1 in RUN → cond=01, sel=5, id_flush=0 (stall wins). Next cycle with only the branch → cond=00, sel=0, id_flush=1.
- md_start pulse, MD_CYCLES=4 → cond=01 for exactly 4 cycles, busy=1 for the last 3. intr_req raised mid-wait → intr_ack only after return to RUN.
- intr_req=1, cp0_ie=1 → intr_ack high 1 cycle. Next cycle cond=01, id_flush=1. Then cond=00, sel=2. Then RUN. With cp0_ie=0 → no ack.
- id_eret and intr_req together → sel=3, intr_ack=0. Next cycle intr_ack=1.
- halt_req → cond=01 for 100 cycles regardless of other inputs. rst pulse → INIT then RUN.
